// File: rtl/bus_arbiter.sv
// bus_arbiter: CPU/device arbiter for one shared memory port with locked device bursts.
// Optional device starvation guard: define BUS_ARBITER_FAIRNESS_EN.
module bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_data_in,
  output logic        cpu_grant,
  output logic        cpu_stall,
  output logic        cpu_valid,
  output logic [15:0] cpu_data_out,
  input  logic        dev_req,
  input  logic        dev_write,
  input  logic        dev_lock,
  input  logic [15:0] dev_address,
  input  logic [15:0] dev_data_in,
  output logic        dev_grant,
  output logic        dev_valid,
  output logic [15:0] dev_data_out,
  output logic        mem_write_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data_out,
  input  logic [15:0] mem_data_in
);
  typedef enum logic [1:0] {IDLE, CPU, DEV, DEV_LOCKED} state_t;
  state_t state_q, state_d;
  logic fair_win, locked;
  logic cpu_rd_q, cpu_rd_d, dev_rd_q, dev_rd_d;
  logic [15:0] cpu_dout_q, cpu_dout_d, dev_dout_q, dev_dout_d;
`ifdef BUS_ARBITER_FAIRNESS_EN
  logic [2:0] starve_q, starve_d;
  assign fair_win = starve_q == 3'(STARVE_LIMIT);
  always_comb starve_d = (!dev_req || dev_grant) ? 3'd0 : (starve_q == 3'd7 ? starve_q : starve_q + 3'd1);
  always_ff @(posedge clock) starve_q <= reset ? 3'd0 : starve_d;
`else
  assign fair_win = STARVE_LIMIT < 0;
`endif
  // The lock only holds while dev_lock stays high; its falling cycle re-arbitrates.
  assign locked = state_q == DEV_LOCKED && dev_lock;
  always_comb begin
    cpu_grant = !reset && !locked && cpu_req && !(dev_req && fair_win);
    dev_grant = !reset && dev_req && !cpu_grant;
    cpu_stall = cpu_req && !cpu_grant;
    mem_write_enable = (cpu_grant && cpu_write) || (dev_grant && dev_write);
    mem_address = cpu_grant ? cpu_address : dev_grant ? dev_address : 16'd0;
    mem_data_out = cpu_grant ? cpu_data_in : dev_grant ? dev_data_in : 16'd0;
    state_d = (locked || (dev_grant && dev_lock)) ? DEV_LOCKED : dev_grant ? DEV : cpu_grant ? CPU : IDLE;
    cpu_rd_d = cpu_grant && !cpu_write;
    dev_rd_d = dev_grant && !dev_write;
    cpu_data_out = cpu_rd_q ? mem_data_in : cpu_dout_q;
    dev_data_out = dev_rd_q ? mem_data_in : dev_dout_q;
    cpu_dout_d = cpu_data_out;
    dev_dout_d = dev_data_out;
  end
  assign cpu_valid = cpu_rd_q;
  assign dev_valid = dev_rd_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cpu_rd_q <= 1'b0;
      dev_rd_q <= 1'b0;
      cpu_dout_q <= 16'd0;
      dev_dout_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cpu_rd_q <= cpu_rd_d;
      dev_rd_q <= dev_rd_d;
      cpu_dout_q <= cpu_dout_d;
      dev_dout_q <= dev_dout_d;
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed table, corner sequences and random traffic against a reference model.
module tb_bus_arbiter;
  logic clock = 1'b0, reset;
  logic cpu_req, cpu_write, dev_req, dev_write, dev_lock;
  logic [15:0] cpu_address, cpu_data_in, dev_address, dev_data_in;
  logic cpu_grant, cpu_stall, cpu_valid, dev_grant, dev_valid, mem_write_enable;
  logic [15:0] cpu_data_out, dev_data_out, mem_address, mem_data_out, mem_data_in;
  int total = 0, passed = 0;
  string tag = "init";
`ifdef BUS_ARBITER_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
    .cpu_grant(cpu_grant), .cpu_stall(cpu_stall), .cpu_valid(cpu_valid), .cpu_data_out(cpu_data_out),
    .dev_req(dev_req), .dev_write(dev_write), .dev_lock(dev_lock), .dev_address(dev_address),
    .dev_data_in(dev_data_in), .dev_grant(dev_grant), .dev_valid(dev_valid), .dev_data_out(dev_data_out),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in)
  );

  always #5 clock = ~clock;

  logic [15:0] tb_mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  always @(posedge clock) begin
    mem_data_in <= tb_mem[mem_address];
    if (mem_write_enable) tb_mem[mem_address] <= mem_data_out;
  end

  // Reference model: who holds the burst lock, how long the device has waited, pending reads.
  bit m_locked, m_pc, m_pd, e_cg, e_dg, e_we;
  int m_starve;
  logic [15:0] m_rdata, m_chold, m_dhold, e_ma;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) $display("FAIL %s %s: got %h want %h", tag, n, a, e);
    else passed++;
  endtask

  task automatic in(input logic rst, cr, cw, input logic [15:0] ca, cd,
                    input logic dr, dw, dl, input logic [15:0] da, dd);
    reset = rst; cpu_req = cr; cpu_write = cw; cpu_address = ca; cpu_data_in = cd;
    dev_req = dr; dev_write = dw; dev_lock = dl; dev_address = da; dev_data_in = dd;
  endtask

  task automatic cycle();
    #1;
    if (reset) begin e_cg = 0; e_dg = 0; end
    else if (m_locked && dev_lock) begin e_cg = 0; e_dg = dev_req; end
    else if (cpu_req && dev_req) begin e_dg = FAIR && m_starve == 4; e_cg = !e_dg; end
    else begin e_cg = cpu_req; e_dg = dev_req; end
    e_ma = e_cg ? cpu_address : e_dg ? dev_address : 16'h0;
    e_we = (e_cg && cpu_write) || (e_dg && dev_write);
    chk("cpu_grant", cpu_grant, e_cg);
    chk("dev_grant", dev_grant, e_dg);
    chk("cpu_stall", cpu_stall, cpu_req && !e_cg);
    chk("mem_we", mem_write_enable, e_we);
    chk("mem_address", mem_address, e_ma);
    if (e_we) chk("mem_data_out", mem_data_out, e_cg ? cpu_data_in : dev_data_in);
    chk("cpu_valid", cpu_valid, m_pc);
    chk("dev_valid", dev_valid, m_pd);
    chk("cpu_data_out", cpu_data_out, m_pc ? m_rdata : m_chold);
    chk("dev_data_out", dev_data_out, m_pd ? m_rdata : m_dhold);
    @(posedge clock);
    if (reset) begin
      m_locked = 0; m_starve = 0; m_pc = 0; m_pd = 0; m_chold = 0; m_dhold = 0;
    end else begin
      if (m_pc) m_chold = m_rdata;
      if (m_pd) m_dhold = m_rdata;
      m_locked = dev_lock && (m_locked || e_dg);
      m_starve = (!dev_req || e_dg) ? 0 : (m_starve < 7 ? m_starve + 1 : 7);
      m_pc = e_cg && !cpu_write;
      m_pd = e_dg && !dev_write;
      if (m_pc || m_pd) m_rdata = ref_mem[e_ma];
      if (e_we) ref_mem[e_ma] = e_cg ? cpu_data_in : dev_data_in;
    end
    @(negedge clock);
  endtask

  typedef struct {
    logic rst, cr, cw; logic [15:0] ca, cd;
    logic dr, dw, dl; logic [15:0] da, dd;
    logic e_cg, e_dg, e_st, e_we; logic [15:0] e_ma;
    logic e_cv; logic [15:0] e_cdo; logic e_dv; logic [15:0] e_ddo;
  } vec_t;
  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1, 1,0,16'h10,0,      1,0,0,16'h20,0,        0,0,1,0,16'h0,  0,16'h0,0,16'h0};
    tbl[1]  = '{0, 1,0,16'h10,0,      0,0,0,16'h0,0,         1,0,0,0,16'h10, 0,16'h0,0,16'h0};
    tbl[2]  = '{0, 0,0,16'h0,0,       0,0,0,16'h0,0,         0,0,0,0,16'h0,  1,16'h1234,0,16'h0};
    tbl[3]  = '{0, 0,0,16'h0,0,       1,1,0,16'h20,16'hBEEF, 0,1,0,1,16'h20, 0,16'h1234,0,16'h0};
    tbl[4]  = '{0, 1,0,16'h20,0,      0,0,0,16'h0,0,         1,0,0,0,16'h20, 0,16'h1234,0,16'h0};
    tbl[5]  = '{0, 0,0,16'h0,0,       0,0,0,16'h0,0,         0,0,0,0,16'h0,  1,16'hBEEF,0,16'h0};
    tbl[6]  = '{0, 1,0,16'h10,0,      1,0,0,16'h20,0,        1,0,0,0,16'h10, 0,16'hBEEF,0,16'h0};
    tbl[7]  = '{0, 1,0,16'h10,0,      1,0,0,16'h20,0,        1,0,0,0,16'h10, 1,16'h1234,0,16'h0};
    tbl[8]  = '{0, 1,0,16'h10,0,      1,0,0,16'h20,0,        1,0,0,0,16'h10, 1,16'h1234,0,16'h0};
    tbl[9]  = '{0, 0,0,16'h0,0,       0,0,0,16'h0,0,         0,0,0,0,16'h0,  1,16'h1234,0,16'h0};
    tbl[10] = '{0, 0,0,16'h0,0,       1,0,0,16'h10,0,        0,1,0,0,16'h10, 0,16'h1234,0,16'h0};
    tbl[11] = '{0, 0,0,16'h0,0,       0,0,0,16'h0,0,         0,0,0,0,16'h0,  0,16'h1234,1,16'h1234};
    tbl[12] = '{0, 1,1,16'h30,16'h5A5A, 0,0,0,16'h0,0,       1,0,0,1,16'h30, 0,16'h1234,0,16'h1234};
    for (int i = 0; i < 65536; i++) begin tb_mem[i] = 16'h0; ref_mem[i] = 16'h0; end
    tb_mem[16'h10] = 16'h1234; ref_mem[16'h10] = 16'h1234;
    m_locked = 0; m_starve = 0; m_pc = 0; m_pd = 0; m_rdata = 0; m_chold = 0; m_dhold = 0;
    in(1, 0,0,16'h0,16'h0, 0,0,0,16'h0,16'h0);
    repeat (2) @(negedge clock);

    for (int i = 0; i < 13; i++) begin
      tag = $sformatf("row%0d", i);
      in(tbl[i].rst, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
         tbl[i].dr, tbl[i].dw, tbl[i].dl, tbl[i].da, tbl[i].dd);
      #1;
      chk("t_cpu_grant", cpu_grant, tbl[i].e_cg);
      chk("t_dev_grant", dev_grant, tbl[i].e_dg);
      chk("t_cpu_stall", cpu_stall, tbl[i].e_st);
      chk("t_mem_we", mem_write_enable, tbl[i].e_we);
      chk("t_mem_address", mem_address, tbl[i].e_ma);
      chk("t_cpu_valid", cpu_valid, tbl[i].e_cv);
      chk("t_cpu_data_out", cpu_data_out, tbl[i].e_cdo);
      chk("t_dev_valid", dev_valid, tbl[i].e_dv);
      chk("t_dev_data_out", dev_data_out, tbl[i].e_ddo);
      cycle();
    end

    for (int i = 1; i <= 6; i++) begin
      tag = $sformatf("contend%0d", i);
      in(0, 1,0,16'h10,16'h0, 1,0,0,16'h20,16'h0);
      #1;
      chk("s_cpu_grant", cpu_grant, !(FAIR && i == 5));
      chk("s_dev_grant", dev_grant, FAIR && i == 5);
      chk("s_cpu_stall", cpu_stall, FAIR && i == 5);
      cycle();
    end

    tag = "burst_acquire";
    in(0, 0,0,16'h0,16'h0, 1,0,1,16'h00FF,16'h0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      tag = $sformatf("burst%0d", i);
      in(0, 1,0,16'h10,16'h0, 1,0,1,16'h0100 + 16'(i),16'h0);
      #1;
      chk("b_cpu_stall", cpu_stall, 1'b1);
      chk("b_dev_grant", dev_grant, 1'b1);
      chk("b_mem_address", mem_address, 16'h0100 + 16'(i));
      cycle();
    end
    tag = "burst_release";
    in(0, 1,0,16'h10,16'h0, 1,0,0,16'h0104,16'h0);
    #1;
    chk("r_cpu_grant", cpu_grant, 1'b1);
    chk("r_dev_grant", dev_grant, 1'b0);
    cycle();

    tag = "rst_burst_lock";
    in(0, 0,0,16'h0,16'h0, 1,0,1,16'h40,16'h0);
    cycle();
    tag = "rst_burst_reset";
    in(1, 1,0,16'h10,16'h0, 1,1,1,16'h41,16'h0);
    #1;
    chk("x_cpu_grant", cpu_grant, 1'b0);
    chk("x_dev_grant", dev_grant, 1'b0);
    chk("x_mem_we", mem_write_enable, 1'b0);
    cycle();
    tag = "rst_burst_after";
    in(0, 1,0,16'h10,16'h0, 1,0,1,16'h42,16'h0);
    #1;
    chk("a_dev_valid", dev_valid, 1'b0);
    chk("a_cpu_grant", cpu_grant, 1'b1);
    chk("a_dev_grant", dev_grant, 1'b0);
    cycle();

    tag = "random";
    for (int i = 0; i < 400; i++) begin
      in(1'($urandom_range(0, 31) == 0),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         16'($urandom_range(0, 15)), 16'($urandom),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
         16'($urandom_range(0, 15)), 16'($urandom));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
